// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver: scans DIGITS nibbles onto one shared active-low
// segment bus, with guard blanking, blank mask, LZS and frame-synchronous loads.
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     blank_i,
    input  logic                  lzs_i,
    input  logic                  load_i,
    output logic                  load_ack_o,
    output logic                  frame_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o
);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    typedef enum logic {ST_ON = 1'b0, ST_GUARD = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                advance, wrap;
    logic                wrap_q, ack_q;

    logic [4*DIGITS-1:0] act_val_q, pend_val_q;
    logic [DIGITS-1:0]   act_dp_q, pend_dp_q;
    logic [DIGITS-1:0]   act_blank_q, pend_blank_q;
    logic                pend_q;

    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   dark;
    logic                upper_zero;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign nib[gi] = act_val_q[4*gi +: 4];
        end
    endgenerate

    // Digit k is LZS-dark when it and every more-significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        dark       = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (nib[k] == 4'h0);
            dark[k]    = act_blank_q[k] | (lzs_i & (k != 0) & upper_zero);
        end
    end

    // Scan FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ON;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Scan FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        advance = 1'b0;
        case (state_q)
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (GUARD_CYCLES > 0) state_d = ST_GUARD;
                    else                  advance = 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ON;
                    advance = 1'b1;
                end
            end
            default: state_d = ST_ON;
        endcase
        if (advance) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        wrap = advance && (idx_q == IDX_LAST);
    end

    // Scan FSM: outputs (registered below)
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_q == ST_ON) begin
            an_d[idx_q] = 1'b0;
            if (!dark[idx_q]) begin
                seg_d = decode(nib[idx_q]);
                dp_d  = ~act_dp_q[idx_q];
            end
        end
    end

    // Active data only changes on the wrap edge so a frame is never torn.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_q       <= 1'b0;
            ack_q        <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            wrap_q <= wrap;
            if (wrap && load_i) begin
                act_val_q   <= value_i;
                act_dp_q    <= dp_i;
                act_blank_q <= blank_i;
                pend_q      <= 1'b0;
                ack_q       <= 1'b1;
            end else if (wrap && pend_q) begin
                act_val_q   <= pend_val_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= pend_blank_q;
                pend_q      <= 1'b0;
                ack_q       <= 1'b1;
            end else if (load_i) begin
                pend_val_q   <= value_i;
                pend_dp_q    <= dp_i;
                pend_blank_q <= blank_i;
                pend_q       <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_o      <= 7'h7F;
            dp_o       <= 1'b1;
            an_o       <= '1;
            load_ack_o <= 1'b0;
            frame_o    <= 1'b0;
        end else begin
            seg_o      <= seg_d;
            dp_o       <= dp_d;
            an_o       <= an_d;
            load_ack_o <= ack_q;
            frame_o    <= wrap_q;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, guard 1 (dut_a) and guard 0 (dut_b).
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  blank_i = '0;
    logic        lzs_i = 1'b0;
    logic        load_i = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, ack_a, ack_b, frame_a, frame_b;
    logic [3:0] an_a, an_b;

    int checks = 0;
    int failures = 0;
    int n = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
        .lzs_i(lzs_i), .load_i(load_i), .load_ack_o(ack_a), .frame_o(frame_a),
        .seg_o(seg_a), .dp_o(dp_a), .an_o(an_a)
    );

    seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
        .lzs_i(lzs_i), .load_i(load_i), .load_ack_o(ack_b), .frame_o(frame_b),
        .seg_o(seg_b), .dp_o(dp_b), .an_o(an_b)
    );

    // Output cycle n (sampled 1 time unit after the n-th edge following reset release).
    function automatic int slot_g1(input int c);
        int pos;
        pos = (c - 1) % 20;
        return (pos % 5 == 4) ? -1 : pos / 5;
    endfunction

    function automatic logic [3:0] an_g1(input int c);
        logic [3:0] one;
        one = 4'b0001;
        if (slot_g1(c) < 0) return 4'hF;
        return ~(one << slot_g1(c));
    endfunction

    function automatic logic [3:0] an_g0(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (((c - 1) % 16) / 4));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        load_i = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (seg_a !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg_a); end
        checks++; if (dp_a !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp_a); end
        checks++; if (an_a !== 4'hF) begin failures++; $display("FAIL reset_an got=%b exp=1111", an_a); end
        checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack_a); end
        checks++; if (frame_a !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_a); end
        checks++; if (an_b !== 4'hF) begin failures++; $display("FAIL reset_an_b got=%b exp=1111", an_b); end
    endtask

    task automatic test_scan_idle;
        do_reset;
        while (n < 45) begin
            tick;
            checks++; if (an_a !== an_g1(n)) begin failures++; $display("FAIL idle_an n=%0d got=%b exp=%b", n, an_a, an_g1(n)); end
            checks++; if (seg_a !== 7'h7F) begin failures++; $display("FAIL idle_seg n=%0d got=%h exp=7f", n, seg_a); end
            checks++; if (frame_a !== (n % 20 == 1 && n > 1)) begin failures++; $display("FAIL idle_frame n=%0d got=%b", n, frame_a); end
            checks++; if (ack_a !== 1'b0) begin failures++; $display("FAIL idle_ack n=%0d got=%b exp=0", n, ack_a); end
        end
    endtask

    task automatic test_load_mid_frame;
        logic [6:0] tab [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        logic [3:0] dpm = 4'b0100;
        logic [6:0] es;
        logic       ed;
        int         sl;
        do_reset;
        while (n < 45) begin
            load_i = (n == 3);
            if (n == 3) begin value_i = 16'h12AF; blank_i = 4'h0; dp_i = dpm; end
            tick;
            sl = slot_g1(n);
            es = 7'h7F; ed = 1'b1;
            if (n > 20 && sl >= 0) begin es = tab[sl]; ed = ~dpm[sl]; end
            checks++; if (an_a !== an_g1(n)) begin failures++; $display("FAIL load_an n=%0d got=%b exp=%b", n, an_a, an_g1(n)); end
            checks++; if (seg_a !== es) begin failures++; $display("FAIL load_seg n=%0d got=%b exp=%b", n, seg_a, es); end
            checks++; if (dp_a !== ed) begin failures++; $display("FAIL load_dp n=%0d got=%b exp=%b", n, dp_a, ed); end
            checks++; if (ack_a !== (n == 21)) begin failures++; $display("FAIL load_ack n=%0d got=%b", n, ack_a); end
            checks++; if (frame_a !== (n % 20 == 1 && n > 1)) begin failures++; $display("FAIL load_frame n=%0d got=%b", n, frame_a); end
        end
        load_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [6:0] es;
        int         acks;
        acks = 0;
        do_reset;
        while (n < 45) begin
            load_i = (n == 2 || n == 7);
            value_i = (n == 2) ? 16'h1111 : 16'h2222;
            blank_i = 4'h0; dp_i = 4'h0;
            tick;
            if (ack_a === 1'b1) acks++;
            es = (n > 20 && slot_g1(n) >= 0) ? 7'h24 : 7'h7F;
            checks++; if (seg_a !== es) begin failures++; $display("FAIL b2b_seg n=%0d got=%b exp=%b", n, seg_a, es); end
            checks++; if (ack_a !== (n == 21)) begin failures++; $display("FAIL b2b_ack n=%0d got=%b", n, ack_a); end
        end
        load_i = 1'b0;
        checks++; if (acks != 1) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_lzs;
        logic [6:0] tab1 [4] = '{7'h40, 7'h30, 7'h7F, 7'h7F};
        logic [6:0] tab2 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        logic [6:0] es;
        int         sl;
        do_reset;
        lzs_i = 1'b1;
        while (n < 60) begin
            load_i = (n == 1 || n == 25);
            value_i = (n == 1) ? 16'h0030 : 16'h0000;
            blank_i = 4'h0; dp_i = 4'h0;
            tick;
            sl = slot_g1(n);
            es = 7'h7F;
            if (sl >= 0 && n > 40) es = tab2[sl];
            else if (sl >= 0 && n > 20) es = tab1[sl];
            checks++; if (seg_a !== es) begin failures++; $display("FAIL lzs_seg n=%0d got=%b exp=%b", n, seg_a, es); end
            checks++; if (an_a !== an_g1(n)) begin failures++; $display("FAIL lzs_an n=%0d got=%b exp=%b", n, an_a, an_g1(n)); end
            checks++; if (ack_a !== (n == 21 || n == 41)) begin failures++; $display("FAIL lzs_ack n=%0d got=%b", n, ack_a); end
        end
        load_i = 1'b0;
        lzs_i  = 1'b0;
    endtask

    task automatic test_wrap_load;
        logic [6:0] tab [4] = '{7'h78, 7'h02, 7'h12, 7'h19};
        logic [6:0] es;
        logic       ed;
        int         sl;
        do_reset;
        while (n < 45) begin
            load_i = (n == 19);
            if (n == 19) begin value_i = 16'h4567; blank_i = 4'h0; dp_i = 4'b0001; end
            tick;
            sl = slot_g1(n);
            es = 7'h7F; ed = 1'b1;
            if (n > 20 && sl >= 0) begin es = tab[sl]; ed = (sl != 0); end
            checks++; if (seg_a !== es) begin failures++; $display("FAIL wrap_seg n=%0d got=%b exp=%b", n, seg_a, es); end
            checks++; if (dp_a !== ed) begin failures++; $display("FAIL wrap_dp n=%0d got=%b exp=%b", n, dp_a, ed); end
            checks++; if (ack_a !== (n == 21)) begin failures++; $display("FAIL wrap_ack n=%0d got=%b", n, ack_a); end
            checks++; if (frame_a !== (n % 20 == 1 && n > 1)) begin failures++; $display("FAIL wrap_frame n=%0d got=%b", n, frame_a); end
        end
        load_i = 1'b0;
    endtask

    task automatic test_no_guard_and_reset;
        logic [6:0] tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        logic [6:0] es;
        do_reset;
        while (n < 37) begin
            load_i = (n == 1 || n == 35);
            value_i = (n == 1) ? 16'h1234 : 16'hFFFF;
            blank_i = 4'h0; dp_i = 4'h0;
            tick;
            es = (n > 16) ? tab[((n - 1) % 16) / 4] : 7'h7F;
            checks++; if (an_b !== an_g0(n)) begin failures++; $display("FAIL ng_an n=%0d got=%b exp=%b", n, an_b, an_g0(n)); end
            checks++; if (seg_b !== es) begin failures++; $display("FAIL ng_seg n=%0d got=%b exp=%b", n, seg_b, es); end
            checks++; if (frame_b !== (n % 16 == 1 && n > 1)) begin failures++; $display("FAIL ng_frame n=%0d got=%b", n, frame_b); end
            checks++; if (ack_b !== (n == 17)) begin failures++; $display("FAIL ng_ack n=%0d got=%b", n, ack_b); end
        end
        load_i = 1'b0;
        reset  = 1'b1;
        tick;
        checks++; if (an_b !== 4'hF) begin failures++; $display("FAIL midrst_an got=%b exp=1111", an_b); end
        checks++; if (seg_b !== 7'h7F) begin failures++; $display("FAIL midrst_seg got=%h exp=7f", seg_b); end
        checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0", ack_b); end
        reset = 1'b0;
        n = 0;
        while (n < 40) begin
            tick;
            checks++; if (seg_b !== 7'h7F) begin failures++; $display("FAIL postrst_seg n=%0d got=%b exp=7f", n, seg_b); end
            checks++; if (ack_b !== 1'b0) begin failures++; $display("FAIL postrst_ack n=%0d got=%b exp=0", n, ack_b); end
            checks++; if (an_b !== an_g0(n)) begin failures++; $display("FAIL postrst_an n=%0d got=%b exp=%b", n, an_b, an_g0(n)); end
        end
    endtask

    initial begin
        test_reset;
        test_scan_idle;
        test_load_mid_frame;
        test_back_to_back;
        test_lzs;
        test_wrap_load;
        test_no_guard_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
